load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter BAD_OP_ERR, default 1, meaning is_load and is_store both high produces an error response (0: request silently ignored).
REQ-003 The block SHALL have clk  input  1  system clock, rising edge.
REQ-004 The block SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have req_valid  input  1  pipeline MEM-stage request present.
REQ-006 The block SHALL have req_ready  output  1  request accepted this cycle; low = stall pipeline.
REQ-007 The block SHALL have is_load / is_store  input  1 each  operation type.
REQ-008 The block SHALL have size  input  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 The block SHALL have sign_ext  input  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-010 The block SHALL have addr  input  32  byte address.
REQ-011 The block SHALL have wdata  input  32  store data, right-justified.
REQ-012 The block SHALL have resp_valid  output  1  one-cycle completion pulse.
REQ-013 The block SHALL have resp_err  output  1  completion is misaligned or illegal; valid with resp_valid.
REQ-014 The block SHALL have rdata  output  32  load result, valid with resp_valid; 0 for stores and errors.
REQ-015 The block SHALL have mem_read / mem_write  output  1 each  data-memory strobes.
REQ-016 The block SHALL have mem_addr  output  32  word address {addr[31:2],2'b00}.
REQ-017 The block SHALL have mem_wdata  output  32  word written at the next rising edge.
REQ-018 The block SHALL have mem_rdata  input  32  combinational read data; 0 when mem_read is low.

Function
REQ-019 The FSM SHALL have states IDLE and RMW_WR; req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on req_valid && req_ready.
REQ-021 Lanes SHALL be little-endian: byte k is bits [8k+7:8k], k=addr[1:0]; a half at addr[1]=h is bits [16h+15:16h].
REQ-022 Misalignment SHALL be defined as half with addr[0]=1, or word with addr[1:0]!=0.
REQ-023 A misaligned request SHALL produce no memory access, and resp_valid=1, resp_err=1, rdata=0 on the next cycle.
REQ-024 An accepted aligned load SHALL assert mem_read combinationally in the acceptance cycle.
REQ-025 On the next edge, rdata SHALL register the lane extracted from mem_rdata, extended per sign_ext, and resp_valid SHALL pulse; latency is 1 cycle.
REQ-026 An accepted aligned word store SHALL assert mem_write with mem_wdata=wdata in the acceptance cycle; resp_valid SHALL pulse on the next cycle.
REQ-027 For a byte or half store, the acceptance cycle SHALL assert mem_read only.
REQ-028 At the next edge of a byte or half store, the merged word SHALL be registered: mem_rdata with the target lane replaced by wdata[7:0] or wdata[15:0]; the FSM SHALL then go to RMW_WR.
REQ-029 In RMW_WR, mem_write SHALL be 1 with mem_wdata equal to the merged register.
REQ-030 The edge leaving RMW_WR SHALL return the FSM to IDLE and pulse resp_valid, giving 2-cycle latency and 1 stall cycle.
REQ-031 If is_load and is_store are both high with BAD_OP_ERR=1, the block SHALL give an error response as in REQ-023.
REQ-032 If both are low, the request SHALL be consumed with no access and no response.
REQ-033 mem_read and mem_write SHALL never both be 1.
REQ-034 Both strobes SHALL be 0 whenever no request is being serviced.
REQ-035 The block SHALL accept back-to-back requests every cycle in IDLE; a new request MAY be accepted in the cycle resp_valid is high.
REQ-036 resp_valid SHALL NOT be held for backpressure.

Reset
REQ-037 While rst_n=0, the block SHALL force state=IDLE, resp_valid=0, resp_err=0, rdata=0, merge register=0, and mem_read=mem_write=0, combinationally gated.
REQ-038 Reset asserted in RMW_WR SHALL abort the store: no write and no response.
REQ-039 After release, req_ready SHALL be 1 in the first cycle.

Structure
REQ-040 The shared package mips_mem_pkg SHALL hold the size encodings SZ_BYTE, SZ_HALF and SZ_WORD and the FSM state typedef.
REQ-041 One combinational sub-module, lsu_lane_align, SHALL perform lane extraction/extension and store merge; the FSM and registers SHALL stay in load_store_unit.

Verification
REQ-042 With mem[0]=50, lw addr 0x0 -> mem_read=1 in the acceptance cycle, resp_valid next cycle, rdata=0x00000032, resp_err=0.
REQ-043 sb wdata=0xAB at addr 0x1 with mem[0]=0x00000032 -> req_ready=0 for 1 cycle, mem_wdata=0x0000AB32 in RMW_WR, resp_valid 2 cycles after acceptance.
REQ-044 Then lb 0x1 -> rdata=0xFFFFFFAB; lbu 0x1 -> 0x000000AB; lhu 0x0 -> 0x0000AB32.
REQ-045 sh addr 0x3 -> no mem_read or mem_write, resp_err=1 next cycle; lw addr 0x2 -> same response.
REQ-046 sh 0x1234 to addr 0x4, with rst_n pulsed low during RMW_WR -> mem[1] unchanged, no resp_valid, req_ready=1 after release.
REQ-047 Back-to-back sw 0x8 then lw 0x8 in consecutive cycles -> no stall, load returns the stored value.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory path: access sizes and LSU FSM states.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [0:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE   = 1'b0;
    localparam lsu_state_t ST_RMW_WR = 1'b1;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts/extends load lanes and merges sub-word store data.
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  byte_sel,
    input  logic [31:0] word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [4:0]  byte_lsb;

    always_comb begin
        byte_lsb  = {byte_sel, 3'b000};
        sel_byte  = word[byte_lsb +: 8];
        sel_half  = byte_sel[1] ? word[31:16] : word[15:0];

        load_data = word;
        merged    = store_data;
        case (size)
            SZ_BYTE: begin
                load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
                merged    = word;
                merged[byte_lsb +: 8] = store_data[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
                merged    = word;
                if (byte_sel[1])
                    merged[31:16] = store_data[15:0];
                else
                    merged[15:0]  = store_data[15:0];
            end
            default: begin
                load_data = word;
                merged    = store_data;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: single-cycle loads and word stores, read-modify-write for byte/half stores.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter bit BAD_OP_ERR = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic [31:0] merge_q;
    logic [29:0] addr_q;

    logic        accept;
    logic        is_word;
    logic        misaligned;
    logic        do_load;
    logic        do_store;
    logic        do_err;
    logic        start_rmw;
    logic [31:0] load_data;
    logic [31:0] merged;

    lsu_lane_align u_align (
        .size       (size),
        .sign_ext   (sign_ext),
        .byte_sel   (addr[1:0]),
        .word       (mem_rdata),
        .store_data (wdata),
        .load_data  (load_data),
        .merged     (merged)
    );

    // Size 11 behaves as a word, so bit 1 alone identifies word accesses.
    always_comb begin
        is_word    = size[1];
        misaligned = is_word ? (addr[1:0] != 2'b00)
                             : ((size == SZ_HALF) && addr[0]);
        req_ready  = (state == ST_IDLE);
        accept     = req_valid && req_ready;
        do_load    = accept && is_load && !is_store && !misaligned;
        do_store   = accept && is_store && !is_load && !misaligned;
        do_err     = accept && (((is_load ^ is_store) && misaligned) ||
                                (is_load && is_store && BAD_OP_ERR));
        start_rmw  = do_store && !is_word;
    end

    // Strobes are gated by rst_n so a reset during RMW_WR never lands a write.
    always_comb begin
        mem_read  = rst_n && (do_load || start_rmw);
        mem_write = rst_n && ((do_store && is_word) || (state == ST_RMW_WR));
        mem_addr  = (state == ST_RMW_WR) ? {addr_q, 2'b00} : {addr[31:2], 2'b00};
        mem_wdata = (state == ST_RMW_WR) ? merge_q : wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rdata      <= '0;
            merge_q    <= '0;
            addr_q     <= '0;
        end else begin
            resp_valid <= do_load || (do_store && is_word) || do_err ||
                          (state == ST_RMW_WR);
            resp_err   <= do_err;
            rdata      <= do_load ? load_data : 32'h0;
            if (start_rmw) begin
                merge_q <= merged;
                addr_q  <= addr[31:2];
            end
            case (state)
                ST_IDLE:   state <= start_rmw ? ST_RMW_WR : ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit against a small word-addressed memory model.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:15];
    int checks = 0;
    int errors = 0;

    load_store_unit #(.BAD_OP_ERR(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_load    (is_load),
        .is_store   (is_store),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .rdata      (rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem_read ? mem[mem_addr[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_write)
            mem[mem_addr[5:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1;
        is_load   = ld;
        is_store  = st;
        size      = sz;
        sign_ext  = sx;
        addr      = a;
        wdata     = wd;
        #1;
    endtask

    task automatic finish_accept();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        #1;
    endtask

    task automatic load_check(input string tag, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] exp);
        issue(1'b1, 1'b0, sz, sx, a, 32'h0);
        check({tag, "_rd_strobe"}, {31'h0, mem_read}, 32'h1);
        finish_accept();
        check({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
        check({tag, "_err"}, {31'h0, resp_err}, 32'h0);
        check({tag, "_rdata"}, rdata, exp);
    endtask

    task automatic sw_check(input string tag, input logic [31:0] a, input logic [31:0] wd);
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, a, wd);
        check({tag, "_wr_strobe"}, {30'h0, mem_read, mem_write}, 32'h1);
        check({tag, "_wdata"}, mem_wdata, wd);
        finish_accept();
        check({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;
        is_load   = 1'b1;
        is_store  = 1'b0;
        size      = SZ_WORD;
        sign_ext  = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        req_valid = 1'b0;
        is_load   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h1);

        sw_check("sw0", 32'h0, 32'd50);
        sw_check("sw4", 32'h4, 32'h55667788);
        load_check("lw0", SZ_WORD, 1'b0, 32'h0, 32'h00000032);

        // sb 0xAB @1: acceptance reads, RMW_WR writes merged word, response one cycle later
        issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h1, 32'h000000AB);
        check("sb_accept_strobes", {30'h0, mem_read, mem_write}, 32'h2);
        finish_accept();
        check("sb_stall", {31'h0, req_ready}, 32'h0);
        check("sb_rmw_strobes", {30'h0, mem_read, mem_write}, 32'h1);
        check("sb_rmw_wdata", mem_wdata, 32'h0000AB32);
        check("sb_rmw_addr", mem_addr, 32'h0);
        check("sb_no_early_resp", {31'h0, resp_valid}, 32'h0);
        @(posedge clk);
        #1;
        check("sb_resp", {31'h0, resp_valid}, 32'h1);
        check("sb_ready_back", {31'h0, req_ready}, 32'h1);
        check("sb_idle_strobes", {30'h0, mem_read, mem_write}, 32'h0);

        load_check("lb1", SZ_BYTE, 1'b1, 32'h1, 32'hFFFFFFAB);
        load_check("lbu1", SZ_BYTE, 1'b0, 32'h1, 32'h000000AB);
        load_check("lhu0", SZ_HALF, 1'b0, 32'h0, 32'h0000AB32);
        load_check("lh0", SZ_HALF, 1'b1, 32'h0, 32'hFFFFAB32);
        load_check("lhu6", SZ_HALF, 1'b0, 32'h6, 32'h00005566);

        // misaligned and illegal requests: no access, error pulse next cycle
        issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h3, 32'h1234);
        check("sh3_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        finish_accept();
        check("sh3_valid", {31'h0, resp_valid}, 32'h1);
        check("sh3_err", {31'h0, resp_err}, 32'h1);
        check("sh3_rdata", rdata, 32'h0);

        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h2, 32'h0);
        check("lw2_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        finish_accept();
        check("lw2_valid", {31'h0, resp_valid}, 32'h1);
        check("lw2_err", {31'h0, resp_err}, 32'h1);
        check("lw2_rdata", rdata, 32'h0);

        issue(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'h0);
        check("badop_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        finish_accept();
        check("badop_resp", {30'h0, resp_valid, resp_err}, 32'h3);

        issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
        check("noop_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        finish_accept();
        check("noop_resp", {31'h0, resp_valid}, 32'h0);

        // sh into mem[1], aborted by reset while in RMW_WR
        issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h4, 32'h1234);
        finish_accept();
        check("sh4_rmw_write", {31'h0, mem_write}, 32'h1);
        check("sh4_rmw_wdata", mem_wdata, 32'h55661234);
        rst_n = 1'b0;
        #1;
        check("abort_no_write", {31'h0, mem_write}, 32'h0);
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_after", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
        load_check("lw4_unchanged", SZ_WORD, 1'b0, 32'h4, 32'h55667788);

        // byte merge into upper lane of mem[1]
        issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h7, 32'hFFFFFF9C);
        finish_accept();
        check("sb7_rmw_wdata", mem_wdata, 32'h9C667788);
        @(posedge clk);
        #1;
        load_check("lw4_merged", SZ_WORD, 1'b0, 32'h4, 32'h9C667788);

        // back-to-back sw then lw, no stall
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'hDEADBEEF);
        check("b2b_sw_write", {30'h0, mem_read, mem_write}, 32'h1);
        @(posedge clk);
        #1;
        is_load  = 1'b1;
        is_store = 1'b0;
        #1;
        check("b2b_ready", {31'h0, req_ready}, 32'h1);
        check("b2b_sw_resp", {31'h0, resp_valid}, 32'h1);
        check("b2b_lw_read", {30'h0, mem_read, mem_write}, 32'h2);
        finish_accept();
        check("b2b_lw_resp", {31'h0, resp_valid}, 32'h1);
        check("b2b_lw_rdata", rdata, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
